// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider with start/stop sequencing and ratio change at period boundaries.
// Optional PERIOD_CNT output enabled by defining CLK_DIV_CTRL_PERIOD_CNT_EN.
module clk_div_ctrl #(
   parameter int CNT_W        = 16,
   parameter int DEFAULT_HALF = 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             CFG_VALID,
   input  logic [CNT_W-1:0] CFG_HALF,
   output logic             CFG_READY,
   output logic             DIV_OUT,
   output logic             TICK,
   output logic             BUSY
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
   ,
   output logic [15:0]      PERIOD_CNT
`endif
);

   localparam logic [CNT_W-1:0] HALF_RST = (DEFAULT_HALF == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_HALF);

   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] half, half_nxt;
   logic [CNT_W-1:0] pend, pend_nxt;
   logic             pend_v, pend_v_nxt;
   logic             div, div_nxt;
   logic             tick, tick_nxt;
   logic             accept;
   logic             wrap;
   logic             boundary;
   logic [CNT_W-1:0] half_m1;

   function automatic logic [CNT_W-1:0] clamp_half(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   assign accept  = CFG_VALID & ~pend_v;
   assign half_m1 = half - CNT_W'(1);
   assign wrap    = (cnt == half_m1);

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      half_nxt   = half;
      pend_nxt   = pend;
      pend_v_nxt = pend_v;
      div_nxt    = div;
      tick_nxt   = 1'b0;
      boundary   = 1'b0;
      case (state)
         IDLE: begin
            div_nxt = 1'b0;
            cnt_nxt = '0;
            if (accept) half_nxt = clamp_half(CFG_HALF);
            if (EN) state_nxt = RUN;
         end
         RUN, STOPPING: begin
            if (accept) begin
               pend_nxt   = clamp_half(CFG_HALF);
               pend_v_nxt = 1'b1;
            end
            // A low phase is never extended: leaving from low drops straight to IDLE.
            if (!div && ((state == RUN && !EN) || state == STOPPING)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               if (state == RUN && !EN) state_nxt = STOPPING;
               if (wrap) begin
                  cnt_nxt  = '0;
                  div_nxt  = ~div;
                  tick_nxt = ~div;
                  boundary = div;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
               if (boundary) begin
                  if (pend_v) begin
                     half_nxt   = pend;
                     pend_v_nxt = 1'b0;
                  end
                  if (state == STOPPING) state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            div_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= IDLE;
         cnt    <= '0;
         half   <= HALF_RST;
         pend   <= '0;
         pend_v <= 1'b0;
         div    <= 1'b0;
         tick   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         half   <= half_nxt;
         pend   <= pend_nxt;
         pend_v <= pend_v_nxt;
         div    <= div_nxt;
         tick   <= tick_nxt;
      end
   end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
   logic [15:0] period_cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) period_cnt <= '0;
      else if (boundary) period_cnt <= period_cnt + 16'd1;
   end

   assign PERIOD_CNT = period_cnt;
`endif

   assign DIV_OUT   = div;
   assign TICK      = tick;
   assign CFG_READY = ~pend_v;
   assign BUSY      = pend_v;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized and directed bench for clk_div_ctrl against a phase-level reference model.
module tb_clk_div_ctrl;

   localparam int CNT_W        = 16;
   localparam int DEFAULT_HALF = 1;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic             EN;
   logic             CFG_VALID;
   logic [CNT_W-1:0] CFG_HALF;
   logic             CFG_READY;
   logic             DIV_OUT;
   logic             TICK;
   logic             BUSY;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
   logic [15:0]      PERIOD_CNT;
`endif

   int checks = 0;
   int errors = 0;

   clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(DEFAULT_HALF)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .EN        (EN),
      .CFG_VALID (CFG_VALID),
      .CFG_HALF  (CFG_HALF),
      .CFG_READY (CFG_READY),
      .DIV_OUT   (DIV_OUT),
      .TICK      (TICK),
      .BUSY      (BUSY)
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
      ,
      .PERIOD_CNT(PERIOD_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   // Reference model: run/stop mode, output level, cycles elapsed in current phase,
   // active half-period and a one-deep queue of offered ratios.
   bit          m_run, m_stop, m_lvl, m_tick;
   int          m_el, m_half;
   int          m_pend[$];
   logic [15:0] m_pcnt;

   task automatic model_reset();
      m_run  = 0;
      m_stop = 0;
      m_lvl  = 0;
      m_tick = 0;
      m_el   = 0;
      m_half = (DEFAULT_HALF == 0) ? 1 : DEFAULT_HALF;
      m_pend.delete();
      m_pcnt = 16'd0;
   endtask

   task automatic model_edge(input bit en, input bit cv, input int ch);
      bit ready, was_run, was_stop;
      int ch1;
      ready    = (m_pend.size() == 0);
      ch1      = (ch == 0) ? 1 : ch;
      was_run  = m_run;
      was_stop = m_stop;
      m_tick   = 0;
      if (!was_run && !was_stop) begin
         if (cv && ready) m_half = ch1;
         if (en) m_run = 1;
      end else begin
         if (!m_lvl && (was_stop || !en)) begin
            m_run  = 0;
            m_stop = 0;
            m_el   = 0;
         end else begin
            if (was_run && !en) begin
               m_run  = 0;
               m_stop = 1;
            end
            if (m_el + 1 == m_half) begin
               m_el = 0;
               if (m_lvl) begin
                  m_lvl  = 0;
                  m_pcnt = m_pcnt + 16'd1;
                  if (m_pend.size() != 0) m_half = m_pend.pop_front();
                  if (was_stop) m_stop = 0;
               end else begin
                  m_lvl  = 1;
                  m_tick = 1;
               end
            end else begin
               m_el++;
            end
         end
         if (cv && ready) m_pend.push_back(ch1);
      end
   endtask

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_val("div_out",   int'(DIV_OUT),   int'(m_lvl));
      check_val("tick",      int'(TICK),      int'(m_tick));
      check_val("busy",      int'(BUSY),      int'(m_pend.size() != 0));
      check_val("cfg_ready", int'(CFG_READY), int'(m_pend.size() == 0));
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
      check_val("period_cnt", int'(PERIOD_CNT), int'(m_pcnt));
`endif
   endtask

   task automatic step(input bit en, input bit cv, input int ch);
      EN        = en;
      CFG_VALID = cv;
      CFG_HALF  = 16'(ch);
      @(posedge CLK);
      model_edge(en, cv, ch);
      #1;
      check_outputs();
   endtask

   task automatic go_idle();
      for (int i = 0; i < 80 && (m_run || m_stop); i++) step(1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 0);
      check_val("idle_reach", int'(DIV_OUT), 0);
   endtask

   task automatic wait_lvl(input bit target);
      for (int i = 0; i < 80 && m_lvl != target; i++) step(1'b1, 1'b0, 0);
      check_val("wait_lvl", int'(DIV_OUT), int'(target));
   endtask

   initial begin
      RST_N     = 1'b0;
      EN        = 1'b0;
      CFG_VALID = 1'b0;
      CFG_HALF  = '0;
      model_reset();
      #3;
      check_outputs();
      @(posedge CLK);
      @(posedge CLK);
      #1;
      // Release with EN already high at divide-by-2.
      EN    = 1'b1;
      RST_N = 1'b1;
      repeat (8) step(1'b1, 1'b0, 0);

      // Ratio set while idle, then run; zero behaves as one; config and EN together.
      go_idle();
      step(1'b0, 1'b1, 3);
      repeat (14) step(1'b1, 1'b0, 0);
      go_idle();
      step(1'b0, 1'b1, 0);
      repeat (6) step(1'b1, 1'b0, 0);
      go_idle();
      step(1'b1, 1'b1, 2);
      repeat (8) step(1'b1, 1'b0, 0);

      // Ratio change mid high phase, second offer while busy must be refused.
      go_idle();
      step(1'b0, 1'b1, 4);
      wait_lvl(1'b1);
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 2);
      step(1'b1, 1'b1, 5);
      step(1'b1, 1'b1, 6);
      repeat (16) step(1'b1, 1'b0, 0);

      // Stop during high phase completes it; EN re-assert while stopping is ignored.
      go_idle();
      step(1'b0, 1'b1, 5);
      wait_lvl(1'b1);
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      repeat (8) step(1'b0, 1'b0, 0);
      // Stop during low phase abandons it.
      wait_lvl(1'b1);
      wait_lvl(1'b0);
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 0);
      repeat (3) step(1'b0, 1'b0, 0);
      // EN falls on the same edge as the period boundary.
      step(1'b0, 1'b1, 2);
      wait_lvl(1'b1);
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 0);
      repeat (3) step(1'b0, 1'b0, 0);

      // Asynchronous reset mid high phase with a config pending.
      step(1'b0, 1'b1, 6);
      wait_lvl(1'b1);
      step(1'b1, 1'b1, 3);
      step(1'b1, 1'b0, 0);
      #2;
      RST_N = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      repeat (6) step(1'b1, 1'b0, 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit en, cv;
         int ch;
         en = ($urandom_range(0, 11) != 0);
         cv = ($urandom_range(0, 4) == 0);
         ch = $urandom_range(0, 6);
         step(en, cv, ch);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for the design's divided clock: generates a 50 % duty divided signal from `CLK` with a programmable half-period, and sequences start, stop and ratio changes so the divided output never glitches. Downstream logic consumes either `DIV_OUT` as a slow level or `TICK` as a single-cycle enable. A valid/ready config port lets a requester change the ratio while running; the change takes effect only at a period boundary.

## Interface
- `CNT_W`, 16: width of half-period value and internal counter.
- `DEFAULT_HALF`, 1: half-period loaded at reset, in `CLK` cycles. 1 gives divide-by-2.

- `CLK`  in  1  system clock; all logic on rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `EN`  in  1  run request; level sensitive.
- `CFG_VALID`  in  1  new half-period offered.
- `CFG_HALF`  in  `CNT_W`  offered half-period; 0 is clamped to 1.
- `CFG_READY`  out  1  config accepted when `CFG_VALID & CFG_READY` at a rising edge.
- `DIV_OUT`  out  1  divided signal.
- `TICK`  out  1  one-cycle pulse, high in the same cycles `DIV_OUT` has just risen.
- `BUSY`  out  1  high while a pending config waits for a boundary.

## Operation
- Registers:
  - `state` ∈ {IDLE, RUN, STOPPING}.
  - `cnt` (`CNT_W`).
  - `half` (active value).
  - `pend` plus `pend_v`.
- Reset values: `state`=IDLE, `cnt`=0, `half`=`DEFAULT_HALF` (0 clamped to 1), `pend_v`=0.
  - Output reset values: `DIV_OUT`=0, `TICK`=0, `CFG_READY`=1, `BUSY`=0.
- IDLE:
  - `DIV_OUT`=0 and `cnt`=0.
  - `EN`=1 sampled → RUN.
  - A config accepted in IDLE writes `half` directly. If `EN` is sampled in the same cycle, RUN uses the new value.
- RUN and STOPPING, each edge:
  - If `cnt == half-1`: `cnt`←0 and `DIV_OUT` toggles.
  - Otherwise `cnt`←`cnt`+1.
- Period boundary: the edge where `DIV_OUT` toggles 1→0.
  - At a boundary with `pend_v`=1: `half`←`pend`, `pend_v`←0.
- RUN with `EN`=0 sampled:
  - If `DIV_OUT`=0: → IDLE and `cnt`←0. The partial low phase is abandoned.
  - If `DIV_OUT`=1: → STOPPING.
- STOPPING:
  - Counts until the boundary, then → IDLE with `cnt`=0. The high phase always completes at full width.
  - `EN` re-asserting in STOPPING is ignored until IDLE is reached. IDLE then restarts on the next sampled `EN`.
- Config port:
  - `CFG_READY` = ~`pend_v`.
  - Acceptance outside IDLE sets `pend`←max(`CFG_HALF`,1) and `pend_v`←1.
  - `BUSY` = `pend_v`.
  - `CFG_HALF` is don't-care when `CFG_VALID`=0.
- `TICK`: registered. It is 1 for exactly the one cycle following each 0→1 toggle of `DIV_OUT`, coincident with `DIV_OUT`'s first high cycle.

## Timing
- Start latency:
  - `EN` first sampled high at edge k → RUN from edge k.
  - `DIV_OUT` rises at edge k+`half` and falls at k+2·`half`.
  - Period is 2·`half` `CLK` cycles.
- `half`=1 gives `DIV_OUT` toggling every edge, i.e. `CLK`/2.
- Config accept and boundary on the same edge: `pend` is written, but not applied until the next boundary.
- `CFG_READY` returns to 1 in the cycle after the boundary that applied `pend`.
- `EN` falling and a boundary on the same edge: the boundary completes the period. `DIV_OUT`=0 after the edge, then → IDLE at the next edge.
- `cnt` compares with `==` against `half-1` only; no wrap beyond `half-1` can occur because `half` changes only when `cnt`=0.
- `RST_N` low mid-operation:
  - All registers take reset values immediately (asynchronous).
  - `DIV_OUT` may therefore shorten a phase.
  - The pending config is discarded.

## Configuration
- `CLK_DIV_CTRL_PERIOD_CNT_EN` defined:
  - Adds output `PERIOD_CNT`, 16 bits.
  - Increments at every period boundary and wraps 0xFFFF→0x0000.
  - Reset to 0 only by `RST_N`; held across IDLE.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset release with `EN`=1, `DEFAULT_HALF`=1 → `DIV_OUT` toggles every edge starting edge 1 after RUN entry; `TICK` high every 2nd cycle.
- IDLE config with `CFG_HALF`=3, then `EN`=1 → `DIV_OUT` 3 high / 3 low cycles. `CFG_HALF`=0 → behaves as 1.
- Running at `half`=4, accept `CFG_HALF`=2 mid high phase:
  - `BUSY`=1 and `CFG_READY`=0 until the next 1→0 edge.
  - Following phases are 2 cycles.
  - A second `CFG_VALID` during `BUSY` is not accepted.
- Running at `half`=5, drop `EN` at the 2nd high cycle → 5-cycle high completes, then `DIV_OUT`=0 and IDLE. Drop `EN` during low phase → IDLE next edge.
- Assert `RST_N`=0 asynchronously mid high phase with config pending → `DIV_OUT`=0 without waiting for an edge; `BUSY`=0; `half`=`DEFAULT_HALF` after release.
- With `CLK_DIV_CTRL_PERIOD_CNT_EN`, `half`=1, run 65 537 periods → `PERIOD_CNT`=1 (wrapped).
